// File: rtl/decoder_pipe_nto2n.sv
// Pipelined N-to-2^N decoder with valid/ready handshakes.
// Emits one-hot, thermometer, active-low one-hot or a one-hot scan sequence.
module decoder_pipe_nto2n #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_err,
    output logic             out_last
);

    localparam int CW = SEL_W + 1;
    localparam logic [CW-1:0]    LAST_K  = CW'(OUT_W - 1);
    localparam logic [CW-1:0]    LIMIT   = CW'(OUT_W);
    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(OUT_W - 1);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic               in_range;
    logic               accept;
    logic               xfer;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] y;
        y = '0;
        for (int i = 0; i < OUT_W; i++) begin
            y[i] = (s == SEL_W'(i));
        end
        return y;
    endfunction

    function automatic logic [OUT_W-1:0] thermo(input logic [SEL_W-1:0] s);
        logic [OUT_W-1:0] y;
        y = '0;
        for (int i = 0; i < OUT_W; i++) begin
            y[i] = ({1'b0, s} >= CW'(i));
        end
        return y;
    endfunction

    assign in_range  = {1'b0, in_sel} < LIMIT;
    assign in_ready  = !rst && (state_q == S_IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = valid_q && out_ready;

    assign out_valid = valid_q;
    assign out_y     = y_q;
    assign out_err   = err_q;
    assign out_last  = last_q;

    // The last scan word is loaded with the FSM back in IDLE, so its
    // transfer and the next accept can share a cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        y_d     = y_q;
        err_d   = err_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    valid_d = 1'b1;
                    err_d   = !in_range;
                    last_d  = 1'b1;
                    idx_d   = in_sel;
                    cnt_d   = '0;
                    if (!in_range) begin
                        y_d = '0;
                    end else begin
                        unique case (in_mode)
                            2'b00: y_d = onehot(in_sel);
                            2'b01: y_d = thermo(in_sel);
                            2'b10: y_d = ~onehot(in_sel);
                            2'b11: begin
                                y_d     = onehot(in_sel);
                                last_d  = 1'b0;
                                state_d = S_SCAN;
                            end
                        endcase
                    end
                end else if (xfer) begin
                    valid_d = 1'b0;
                end
            end
            S_SCAN: begin
                if (xfer) begin
                    idx_d  = (idx_q == MAX_IDX) ? '0 : idx_q + 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    y_d    = onehot(idx_d);
                    last_d = (cnt_d == LAST_K);
                    if (last_d) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

endmodule
